// File: rtl/cart_pkg.sv
// Shared types and helpers for the cartridge bank-switch mapper.
// Scheme encoding matches the loader's scheme field (0=4K, 1=F8, 2=F6, 3=F4).
package cart_pkg;

    typedef enum logic [1:0] {
        SCH_4K = 2'd0,
        SCH_F8 = 2'd1,
        SCH_F6 = 2'd2,
        SCH_F4 = 2'd3
    } scheme_t;

    localparam logic [11:0] HS_F8 = 12'hFF8;
    localparam logic [11:0] HS_F6 = 12'hFF6;
    localparam logic [11:0] HS_F4 = 12'hFF4;

    localparam int SC_DEPTH = 128;
    localparam int SC_AW    = 7;

    function automatic logic [2:0] last_bank(input scheme_t s);
        case (s)
            SCH_F8:  last_bank = 3'd1;
            SCH_F6:  last_bank = 3'd3;
            SCH_F4:  last_bank = 3'd7;
            default: last_bank = 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] bank_mask(input scheme_t s);
        case (s)
            SCH_F8:  bank_mask = 3'b001;
            SCH_F6:  bank_mask = 3'b011;
            SCH_F4:  bank_mask = 3'b111;
            default: bank_mask = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/cart_mapper_if.sv
// CPU-side cartridge bus: CPU address/data in, banked ROM address and SC read path out.
// master = CPU/top side, slave = mapper.
interface cart_mapper_if #(
    parameter int ROM_AW = 15
);
    logic              cpu_en_i;
    logic [12:0]       cpu_addr_i;
    logic              cpu_rnw_i;
    logic [7:0]        cpu_dat_i;
    logic [ROM_AW-1:0] rom_addr_o;
    logic              sc_hit_o;
    logic [7:0]        sc_dat_o;

    modport master (
        output cpu_en_i, cpu_addr_i, cpu_rnw_i, cpu_dat_i,
        input  rom_addr_o, sc_hit_o, sc_dat_o
    );

    modport slave (
        input  cpu_en_i, cpu_addr_i, cpu_rnw_i, cpu_dat_i,
        output rom_addr_o, sc_hit_o, sc_dat_o
    );
endinterface

// File: rtl/cart_sc_ram.sv
// 128x8 Superchip cartridge RAM: one write port, registered read every clk.
// Array contents are never reset; only the read register is.
import cart_pkg::*;

module cart_sc_ram (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_we,
    input  logic [SC_AW-1:0] i_addr,
    input  logic [7:0]       i_wdat,
    output logic [7:0]       o_rdat
);
    logic [7:0] r_mem [SC_DEPTH];
    logic [7:0] r_rdat;

    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdat <= 8'h00;
        end else begin
            r_rdat <= r_mem[i_addr];
        end
    end

    assign o_rdat = r_rdat;
endmodule

// File: rtl/cart_mapper.sv
// Cartridge bank-switch mapper: F8/F6/F4 hotspot decode, bank register, switch counter.
// Optional Superchip RAM is built when CART_SUPERCHIP_EN is defined.
import cart_pkg::*;

module cart_mapper #(
    parameter int ROM_AW     = 15,
    parameter bit RESET_LAST = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    cart_mapper_if.slave        bus,
    input  logic [1:0]          scheme_i,
    input  logic                scheme_we_i,
    output logic [2:0]          bank_o,
    output logic [15:0]         switch_cnt_o
);
    scheme_t     r_scheme;
    logic [2:0]  r_bank;
    logic [15:0] r_switch_cnt;

    logic [11:0] w_off;
    logic        w_hit;
    logic [2:0]  w_sel;
    scheme_t     w_new_scheme;

    assign w_off        = bus.cpu_addr_i[11:0];
    assign w_new_scheme = scheme_t'(scheme_i);

    // Hotspot offset minus the scheme's base gives the bank directly.
    always_comb begin
        w_hit = 1'b0;
        w_sel = 3'd0;
        if (bus.cpu_en_i && bus.cpu_addr_i[12]) begin
            case (r_scheme)
                SCH_F8: if (w_off >= HS_F8 && w_off <= HS_F8 + 12'd1) begin
                    w_hit = 1'b1;
                    w_sel = 3'(w_off - HS_F8);
                end
                SCH_F6: if (w_off >= HS_F6 && w_off <= HS_F6 + 12'd3) begin
                    w_hit = 1'b1;
                    w_sel = 3'(w_off - HS_F6);
                end
                SCH_F4: if (w_off >= HS_F4 && w_off <= HS_F4 + 12'd7) begin
                    w_hit = 1'b1;
                    w_sel = 3'(w_off - HS_F4);
                end
                default: ;
            endcase
        end
    end

    // A scheme load overrides any coincident hotspot hit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scheme     <= SCH_4K;
            r_bank       <= 3'd0;
            r_switch_cnt <= 16'd0;
        end else if (scheme_we_i) begin
            r_scheme <= w_new_scheme;
            r_bank   <= RESET_LAST ? last_bank(w_new_scheme) : 3'd0;
        end else if (w_hit) begin
            r_bank       <= w_sel & bank_mask(r_scheme);
            r_switch_cnt <= r_switch_cnt + 16'd1;
        end
    end

    assign bus.rom_addr_o = {r_bank[ROM_AW-13:0], bus.cpu_addr_i[11:0]};
    assign bank_o         = r_bank;
    assign switch_cnt_o   = r_switch_cnt;

`ifdef CART_SUPERCHIP_EN
    logic       w_sc_we;
    logic [7:0] w_sc_rdat;

    assign w_sc_we = bus.cpu_en_i && !bus.cpu_rnw_i && bus.cpu_addr_i[12]
                     && (bus.cpu_addr_i[11:7] == 5'b00000);

    cart_sc_ram u_sc_ram (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_we   (w_sc_we),
        .i_addr (bus.cpu_addr_i[6:0]),
        .i_wdat (bus.cpu_dat_i),
        .o_rdat (w_sc_rdat)
    );

    assign bus.sc_hit_o = bus.cpu_rnw_i && bus.cpu_addr_i[12]
                          && (bus.cpu_addr_i[11:7] == 5'b00001);
    assign bus.sc_dat_o = w_sc_rdat;
`else
    logic w_unused_dat;
    assign w_unused_dat = ^bus.cpu_dat_i;
    assign bus.sc_hit_o = 1'b0;
    assign bus.sc_dat_o = 8'h00;
`endif

endmodule

// File: tb/tb_cart_mapper.sv
// Directed bench for cart_mapper: hotspot switching, scheme loads, async reset,
// Superchip RAM window (expectations follow CART_SUPERCHIP_EN) and counter wrap.
module tb_cart_mapper;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  scheme;
    logic        scheme_we;
    logic [2:0]  bank;
    logic [15:0] cnt;
    int          total = 0;
    int          bad   = 0;

`ifdef CART_SUPERCHIP_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    cart_mapper_if #(.ROM_AW(15)) bus ();

    cart_mapper #(.ROM_AW(15), .RESET_LAST(1'b1)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .bus          (bus),
        .scheme_i     (scheme),
        .scheme_we_i  (scheme_we),
        .bank_o       (bank),
        .switch_cnt_o (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One-clk CPU access; outputs settle before the following negedge.
    task automatic strobe(input logic [12:0] a, input logic rnw, input logic [7:0] d);
        @(negedge clk);
        bus.cpu_addr_i = a;
        bus.cpu_rnw_i  = rnw;
        bus.cpu_dat_i  = d;
        bus.cpu_en_i   = 1'b1;
        @(negedge clk);
        bus.cpu_en_i   = 1'b0;
    endtask

    task automatic load(input logic [1:0] s);
        @(negedge clk);
        scheme    = s;
        scheme_we = 1'b1;
        @(negedge clk);
        scheme_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        scheme         = 2'd0;
        scheme_we      = 1'b0;
        bus.cpu_en_i   = 1'b0;
        bus.cpu_addr_i = 13'h1234;
        bus.cpu_rnw_i  = 1'b1;
        bus.cpu_dat_i  = 8'h00;
        #12;
        chk("rst_bank", 32'(bank), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_romaddr", 32'(bus.rom_addr_o), 32'h0234);
        chk("rst_schit", 32'(bus.sc_hit_o), 32'd0);
        chk("rst_scdat", 32'(bus.sc_dat_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // F8
        load(2'd1);
        chk("f8_load", 32'(bank), 32'd1);
        strobe(13'h1FF8, 1'b1, 8'h00);
        chk("f8_bank0", 32'(bank), 32'd0);
        bus.cpu_addr_i = 13'h1234;
        #1 chk("f8_addr0", 32'(bus.rom_addr_o), 32'h0234);
        strobe(13'h1FF9, 1'b1, 8'h00);
        chk("f8_bank1", 32'(bank), 32'd1);
        bus.cpu_addr_i = 13'h1234;
        #1 chk("f8_addr1", 32'(bus.rom_addr_o), 32'h1234);
        chk("f8_cnt", 32'(cnt), 32'd2);
        strobe(13'h0FF8, 1'b1, 8'h00);
        chk("f8_noa12", 32'(bank), 32'd1);

        // F4
        load(2'd3);
        chk("f4_load", 32'(bank), 32'd7);
        @(negedge clk);
        bus.cpu_addr_i = 13'h1FF6;
        bus.cpu_rnw_i  = 1'b0;
        bus.cpu_en_i   = 1'b1;
        #1 chk("f4_oldbank", 32'(bus.rom_addr_o), 32'h7FF6);
        @(negedge clk);
        bus.cpu_en_i   = 1'b0;
        bus.cpu_rnw_i  = 1'b1;
        chk("f4_bank2", 32'(bank), 32'd2);
        chk("f4_cnt", 32'(cnt), 32'd3);
        strobe(13'h1FFC, 1'b1, 8'h00);
        chk("f4_ffc_bank", 32'(bank), 32'd2);
        chk("f4_ffc_cnt", 32'(cnt), 32'd3);

        // 4K: no hotspots
        load(2'd0);
        strobe(13'h1FF8, 1'b1, 8'h00);
        chk("k4_bank", 32'(bank), 32'd0);
        chk("k4_cnt", 32'(cnt), 32'd3);

        // F6 from reset
        do_reset();
        load(2'd2);
        chk("f6_load", 32'(bank), 32'd3);
        @(negedge clk);
        bus.cpu_addr_i = 13'h1FF7;
        bus.cpu_en_i   = 1'b0;
        @(negedge clk);
        chk("f6_noen", 32'(bank), 32'd3);
        bus.cpu_en_i = 1'b1;
        repeat (3) @(negedge clk);
        bus.cpu_en_i = 1'b0;
        chk("f6_rep_bank", 32'(bank), 32'd1);
        chk("f6_rep_cnt", 32'(cnt), 32'd3);

        // Scheme load coincident with a hit
        @(negedge clk);
        bus.cpu_addr_i = 13'h1FF8;
        bus.cpu_en_i   = 1'b1;
        scheme         = 2'd2;
        scheme_we      = 1'b1;
        @(negedge clk);
        bus.cpu_en_i   = 1'b0;
        scheme_we      = 1'b0;
        chk("coin_bank", 32'(bank), 32'd3);
        chk("coin_cnt", 32'(cnt), 32'd3);

        // Asynchronous reset away from any edge
        #2 rst_n = 1'b0;
        #1 chk("arst_bank", 32'(bank), 32'd0);
        chk("arst_cnt", 32'(cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Superchip windows
        strobe(13'h1005, 1'b0, 8'hA5);
        chk("sc_wr_cnt", 32'(cnt), 32'd0);
        @(negedge clk);
        bus.cpu_addr_i = 13'h1085;
        bus.cpu_rnw_i  = 1'b1;
        bus.cpu_en_i   = 1'b1;
        #1 chk("sc_hit", 32'(bus.sc_hit_o), SC ? 32'd1 : 32'd0);
        chk("sc_romaddr", 32'(bus.rom_addr_o), 32'h0085);
        @(negedge clk);
        bus.cpu_en_i = 1'b0;
        chk("sc_dat", 32'(bus.sc_dat_o), SC ? 32'hA5 : 32'h00);
        bus.cpu_addr_i = 13'h1000;
        #1 chk("sc_wrwin_hit", 32'(bus.sc_hit_o), 32'd0);

        // Counter wrap
        load(2'd1);
        @(negedge clk);
        bus.cpu_addr_i = 13'h1FF8;
        bus.cpu_en_i   = 1'b1;
        repeat (65535) @(negedge clk);
        bus.cpu_en_i = 1'b0;
        chk("wrap_pre", 32'(cnt), 32'd65535);
        strobe(13'h1FF9, 1'b1, 8'h00);
        chk("wrap_cnt", 32'(cnt), 32'd0);
        chk("wrap_bank", 32'(bank), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
